// File: rtl/joy_pkg.sv
// Shared constants and pad-word helper for the joystick -> Videopac adapter.
package joy_pkg;

  localparam int JOY_W = 12;
  localparam int PAD_W = 5;

  // Decoder bit order: MXYZ SACB RLDU
  localparam int JOY_U = 0;
  localparam int JOY_D = 1;
  localparam int JOY_L = 2;
  localparam int JOY_R = 3;
  localparam int JOY_B = 4;
  localparam int JOY_C = 5;
  localparam int JOY_A = 6;
  localparam int JOY_S = 7;
  localparam int JOY_Z = 8;
  localparam int JOY_Y = 9;
  localparam int JOY_X = 10;
  localparam int JOY_M = 11;

  // Videopac joystick word fields
  localparam int PAD_U    = 0;
  localparam int PAD_D    = 1;
  localparam int PAD_L    = 2;
  localparam int PAD_R    = 3;
  localparam int PAD_FIRE = 4;

  typedef logic [PAD_W-1:0] pad_t;

  // Active-high debounced pad -> Videopac word; opposing directions cancel.
  function automatic pad_t joy_to_pad(input logic [JOY_W-1:0] s, input logic xyz_gate);
    pad_t p;
    p = '0;
    p[PAD_U]    = s[JOY_U] & ~s[JOY_D];
    p[PAD_D]    = s[JOY_D] & ~s[JOY_U];
    p[PAD_L]    = s[JOY_L] & ~s[JOY_R];
    p[PAD_R]    = s[JOY_R] & ~s[JOY_L];
    p[PAD_FIRE] = s[JOY_A] | s[JOY_B] | s[JOY_C] |
                  ((s[JOY_X] | s[JOY_Y] | s[JOY_Z]) & xyz_gate);
    return p;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit frame debouncer: a bit changes only after FRAMES consecutive
// differing samples.
module joy_debounce #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam logic [3:0] FR = 4'(FRAMES);

  logic [3:0]       count      [WIDTH];
  logic [3:0]       count_next [WIDTH];
  logic [WIDTH-1:0] stable_next;

  // Next stable value and disagreement count for every bit
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      stable_next[i] = stable[i];
      count_next[i]  = count[i];
      if (raw[i] == stable[i]) begin
        count_next[i] = '0;
      end else if (count[i] + 4'd1 == FR) begin
        stable_next[i] = raw[i];
        count_next[i]  = '0;
      end else begin
        count_next[i] = count[i] + 4'd1;
      end
    end
  end

  // State advances only on frame ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) count[i] <= '0;
    end else if (tick) begin
      stable <= stable_next;
      count  <= count_next;
    end
  end

endmodule

// File: rtl/joy_videopac_if.sv
// Converts two Mega Drive pads into Videopac joystick words, paced by vsync.
module joy_videopac_if
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned AUTOFIRE_HALF   = 3,
  parameter int unsigned HOLD_FRAMES     = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync_n_s,
  input  logic [JOY_W-1:0] joy1_i,
  input  logic [JOY_W-1:0] joy2_i,
  input  logic             swap_i,
  input  logic             autofire_en_i,
  output logic [PAD_W-1:0] pad0_o,
  output logic [PAD_W-1:0] pad1_o,
  output logic             osd_req_o
);

  localparam logic [3:0] AF_LAST  = 4'(AUTOFIRE_HALF - 1);
  localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);

  logic [1:0]         vs_hist;
  logic               tick;
  logic               tick_d;
  logic [2*JOY_W-1:0] raw;
  logic [2*JOY_W-1:0] stable;
  logic [3:0]         af_count;
  logic               phase;
  logic               swap_q;
  logic [7:0]         hold;
  logic               xyz_gate;
  pad_t               pad_a;
  pad_t               pad_b;
  logic               unused_menu2;

  assign raw          = ~{joy2_i, joy1_i};
  assign unused_menu2 = stable[JOY_W+JOY_M] ^ stable[JOY_W+JOY_S];

  // Frame tick detection; tick is registered so state updates one edge later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_hist <= 2'b11;
      tick    <= 1'b0;
      tick_d  <= 1'b0;
    end else begin
      vs_hist <= {vs_hist[0], vsync_n_s};
      tick    <= vs_hist[1] & ~vs_hist[0];
      tick_d  <= tick;
    end
  end

  joy_debounce #(
    .WIDTH  (2*JOY_W),
    .FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .raw    (raw),
    .stable (stable)
  );

  // Shared autofire phase; held in the "fire" phase while autofire is off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      af_count <= '0;
      phase    <= 1'b1;
    end else if (!autofire_en_i) begin
      af_count <= '0;
      phase    <= 1'b1;
    end else if (tick) begin
      if (af_count == AF_LAST) begin
        af_count <= '0;
        phase    <= ~phase;
      end else begin
        af_count <= af_count + 4'd1;
      end
    end
  end

  // Player swap is frame-aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) swap_q <= 1'b0;
    else if (tick) swap_q <= swap_i;
  end

  // Pad words from debounced state
  always_comb begin
    xyz_gate = phase | ~autofire_en_i;
    pad_a    = joy_to_pad(stable[JOY_W-1:0], xyz_gate);
    pad_b    = joy_to_pad(stable[2*JOY_W-1:JOY_W], xyz_gate);
  end

  // MODE+START hold counter on physical pad 1; it runs one edge after the
  // debouncer so it sees this frame's stable value, and drives the
  // registered request directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      osd_req_o <= 1'b0;
    end else begin
      osd_req_o <= 1'b0;
      if (tick_d) begin
        if (stable[JOY_M] & stable[JOY_S]) begin
          if (hold != HOLD_MAX) hold <= hold + 8'd1;
          osd_req_o <= (hold == HOLD_MAX - 8'd1);
        end else begin
          hold <= '0;
        end
      end
    end
  end

  // Output registers load once per frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad0_o <= '0;
      pad1_o <= '0;
    end else if (tick_d) begin
      pad0_o <= swap_q ? pad_b : pad_a;
      pad1_o <= swap_q ? pad_a : pad_b;
    end
  end

endmodule
